i2c_read_word: RTL and testbench

I2C master read engine in the sensor-control path: it writes a register pointer to a slave, issues a repeated START, then reads two data bytes (MSB then LSB) into a 16-bit result. It is the read counterpart of the existing single-byte I2C write master. It shares the same PT_CK bit-tick clock, GO/END_OK handshake and open-drain SDAO/SCLO drive style, so both engines can be muxed onto one bus by the controller above.

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_byte_shift.sv | 82 ++++++++
 rtl/i2c_read_word.sv | 181 ++++++++++++++++++
 tb/tb_i2c_read_word.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, bit-phase and framing constants for the I2C read engine.
`default_nettype none

package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LAUNCH,
    ST_START,
    ST_WADDR,
    ST_WPTR,
    ST_RSTART,
    ST_RADDR,
    ST_RMSB,
    ST_RLSB,
    ST_STOP,
    ST_DONE
  } state_e;

  localparam logic [1:0] PH_L0 = 2'd0;
  localparam logic [1:0] PH_L1 = 2'd1;
  localparam logic [1:0] PH_H  = 2'd2;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  localparam int unsigned BITS_PER_BYTE = 9;
  localparam logic [3:0]  LAST_BIT      = 4'(BITS_PER_BYTE - 1);

endpackage

`default_nettype wire

// File: rtl/i2c_byte_shift.sv
// i2c_byte_shift: one byte plus ACK slot, 3 PT_CK phases per bit (L0, L1, H), MSB first.
`default_nettype none

module i2c_byte_shift
  import i2c_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       mack_i,
  input  logic       sda_prev_i,
  input  logic       sdai_i,
  output logic       sda_o,
  output logic       scl_o,
  output logic [7:0] rx_byte_o,
  output logic       ack_o,
  output logic       done_o
);

  logic [1:0] phase_q, phase_d;
  logic [3:0] bit_q, bit_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_q, rx_d;
  logic       tx_bit;

  assign rx_byte_o = rx_q;
  // ACK slot sample; only meaningful in the cycle done_o is high.
  assign ack_o     = sdai_i;
  assign done_o    = busy_q && (bit_q == LAST_BIT) && (phase_q == PH_H);

  always_comb begin
    tx_bit  = (bit_q == LAST_BIT) ? mack_i : tx_byte_i[3'd7 - bit_q[2:0]];
    sda_o   = 1'b1;
    scl_o   = 1'b1;
    phase_d = phase_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    rx_d    = rx_q;
    if (busy_q) begin
      case (phase_q)
        // SDA holds its previous level while SCL falls.
        PH_L0: begin sda_o = sda_prev_i; scl_o = 1'b0; end
        PH_L1: begin sda_o = tx_bit;     scl_o = 1'b0; end
        default: begin sda_o = tx_bit;   scl_o = 1'b1; end
      endcase
      if (phase_q == PH_H) begin
        phase_d = PH_L0;
        if (bit_q == LAST_BIT) begin
          bit_d  = 4'd0;
          busy_d = start_i;
        end else begin
          bit_d = bit_q + 4'd1;
          rx_d  = {rx_q[6:0], sdai_i};
        end
      end else begin
        phase_d = phase_q + 2'd1;
      end
    end else if (start_i) begin
      busy_d  = 1'b1;
      phase_d = PH_L0;
      bit_d   = 4'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= PH_L0;
      bit_q   <= 4'd0;
      busy_q  <= 1'b0;
      rx_q    <= 8'h00;
    end else begin
      phase_q <= phase_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      rx_q    <= rx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_read_word.sv
// i2c_read_word: pointer write, repeated START, 2-byte read into DATA16.
// Optional macro I2C_READ_NACK_ABORT_EN: a slave NACK jumps straight to STOP.
`default_nettype none

module i2c_read_word
  import i2c_pkg::*;
(
  input  logic        RESET_N,
  input  logic        PT_CK,
  input  logic        GO,
  input  logic [7:0]  SLAVE_ADDRESS,
  input  logic [7:0]  POINTER,
  input  logic        SDAI,
  output logic        SDAO,
  output logic        SCLO,
  output logic        END_OK,
  output logic        ACK_OK,
  output logic [15:0] DATA16
);

  state_e      state_q, state_d;
  logic [1:0]  seq_q, seq_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  msb_q, msb_d;
  logic        nack_q, nack_d;
  logic        end_ok_q, end_ok_d;
  logic        ack_ok_q, ack_ok_d;
  logic [15:0] data_q, data_d;
  logic        sda_last_q;

  logic        sh_start, sh_sda, sh_scl, sh_ack, sh_done, sh_mack, abort;
  logic [7:0]  sh_tx, sh_rx;
  logic        unused_addr_rw;

  assign unused_addr_rw = SLAVE_ADDRESS[0];
  assign END_OK = end_ok_q;
  assign ACK_OK = ack_ok_q;
  assign DATA16 = data_q;

  i2c_byte_shift u_shift (
    .clk_i      (PT_CK),
    .rst_ni     (RESET_N),
    .start_i    (sh_start),
    .tx_byte_i  (sh_tx),
    .mack_i     (sh_mack),
    .sda_prev_i (sda_last_q),
    .sdai_i     (SDAI),
    .sda_o      (sh_sda),
    .scl_o      (sh_scl),
    .rx_byte_o  (sh_rx),
    .ack_o      (sh_ack),
    .done_o     (sh_done)
  );

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    addr_d   = addr_q;
    ptr_d    = ptr_q;
    msb_d    = msb_q;
    nack_d   = nack_q;
    end_ok_d = end_ok_q;
    ack_ok_d = ack_ok_q;
    data_d   = data_q;
    sh_start = 1'b0;
    sh_tx    = 8'hFF;
    sh_mack  = 1'b1;
    SDAO     = 1'b1;
    SCLO     = 1'b1;
`ifdef I2C_READ_NACK_ABORT_EN
    abort    = sh_done & sh_ack;
`else
    abort    = 1'b0;
`endif
    case (state_q)
      ST_IDLE:  if (GO)  state_d = ST_ARMED;
      ST_ARMED: if (!GO) state_d = ST_LAUNCH;
      ST_LAUNCH: begin
        addr_d   = SLAVE_ADDRESS[7:1];
        ptr_d    = POINTER;
        nack_d   = 1'b0;
        ack_ok_d = 1'b0;
        end_ok_d = 1'b0;
        state_d  = ST_START;
      end
      ST_START: begin
        SDAO     = 1'b0;
        sh_start = 1'b1;
        state_d  = ST_WADDR;
      end
      ST_WADDR, ST_WPTR, ST_RADDR: begin
        SDAO  = sh_sda;
        SCLO  = sh_scl;
        sh_tx = (state_q == ST_WADDR) ? {addr_q, I2C_WR} :
                (state_q == ST_WPTR)  ? ptr_q : {addr_q, I2C_RD};
        if (sh_done) begin
          nack_d = nack_q | sh_ack;
          if (abort) begin
            state_d = ST_STOP;
          end else if (state_q == ST_WPTR) begin
            state_d = ST_RSTART;
          end else begin
            sh_start = 1'b1;
            state_d  = (state_q == ST_WADDR) ? ST_WPTR : ST_RMSB;
          end
        end
      end
      ST_RSTART: begin
        SDAO  = (seq_q != 2'd2);
        SCLO  = (seq_q != 2'd0);
        seq_d = seq_q + 2'd1;
        if (seq_q == 2'd2) begin
          seq_d    = 2'd0;
          sh_start = 1'b1;
          state_d  = ST_RADDR;
        end
      end
      ST_RMSB: begin
        SDAO    = sh_sda;
        SCLO    = sh_scl;
        sh_mack = 1'b0;
        if (sh_done) begin
          msb_d    = sh_rx;
          sh_start = 1'b1;
          state_d  = ST_RLSB;
        end
      end
      ST_RLSB: begin
        SDAO = sh_sda;
        SCLO = sh_scl;
        if (sh_done) begin
          data_d   = {msb_q, sh_rx};
          ack_ok_d = ~nack_q;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        SDAO  = (seq_q == 2'd2);
        SCLO  = (seq_q != 2'd0);
        seq_d = seq_q + 2'd1;
        if (seq_q == 2'd2) begin
          seq_d    = 2'd0;
          end_ok_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      seq_q      <= 2'd0;
      addr_q     <= 7'h00;
      ptr_q      <= 8'h00;
      msb_q      <= 8'h00;
      nack_q     <= 1'b0;
      end_ok_q   <= 1'b1;
      ack_ok_q   <= 1'b0;
      data_q     <= 16'h0000;
      sda_last_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      addr_q     <= addr_d;
      ptr_q      <= ptr_d;
      msb_q      <= msb_d;
      nack_q     <= nack_d;
      end_ok_q   <= end_ok_d;
      ack_ok_q   <= ack_ok_d;
      data_q     <= data_d;
      sda_last_q <= SDAO;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_read_word.sv
// tb_i2c_read_word: directed transactions against a cycle-exact bus waveform and slave model.
`default_nettype none

module tb_i2c_read_word;

  logic        RESET_N, PT_CK, GO, SDAI;
  logic [7:0]  SLAVE_ADDRESS, POINTER;
  logic        SDAO, SCLO, END_OK, ACK_OK;
  logic [15:0] DATA16;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_bus[$];
  logic       exp_sdai[$];
  logic       last_sda;

`ifdef I2C_READ_NACK_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  i2c_read_word dut (
    .RESET_N       (RESET_N),
    .PT_CK         (PT_CK),
    .GO            (GO),
    .SLAVE_ADDRESS (SLAVE_ADDRESS),
    .POINTER       (POINTER),
    .SDAI          (SDAI),
    .SDAO          (SDAO),
    .SCLO          (SCLO),
    .END_OK        (END_OK),
    .ACK_OK        (ACK_OK),
    .DATA16        (DATA16)
  );

  initial PT_CK = 1'b0;
  always #5 PT_CK = ~PT_CK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic sda, input logic scl, input logic sin);
    exp_bus.push_back({sda, scl});
    exp_sdai.push_back(sin);
    last_sda = sda;
  endtask

  // One byte + ACK slot: L0 keeps SDA, L1/H carry the bit; slave drives sin for the whole bit.
  task automatic push_byte(input logic [7:0] tx, input logic mack, input logic rx_mode,
                           input logic [7:0] rxd, input logic snack);
    logic b, s;
    for (int i = 0; i < 9; i++) begin
      b = (i < 8) ? tx[7-i] : mack;
      s = (i < 8) ? (rx_mode ? rxd[7-i] : 1'b1) : (rx_mode ? 1'b1 : snack);
      push(last_sda, 1'b0, s);
      push(b, 1'b0, s);
      push(b, 1'b1, s);
    end
  endtask

  task automatic build(input logic [7:0] addr, input logic [7:0] ptr, input logic [7:0] msb,
                       input logic [7:0] lsb, input int nack_idx);
    bit go_on;
    go_on = 1'b1;
    exp_bus.delete();
    exp_sdai.delete();
    last_sda = 1'b1;
    push(1'b0, 1'b1, 1'b1);
    push_byte({addr[7:1], 1'b0}, 1'b1, 1'b0, 8'h00, nack_idx == 1);
    if (ABORT_EN && nack_idx == 1) go_on = 1'b0;
    if (go_on) begin
      push_byte(ptr, 1'b1, 1'b0, 8'h00, nack_idx == 2);
      if (ABORT_EN && nack_idx == 2) go_on = 1'b0;
    end
    if (go_on) begin
      push(1'b1, 1'b0, 1'b1);
      push(1'b1, 1'b1, 1'b1);
      push(1'b0, 1'b1, 1'b1);
      push_byte({addr[7:1], 1'b1}, 1'b1, 1'b0, 8'h00, nack_idx == 3);
      if (ABORT_EN && nack_idx == 3) go_on = 1'b0;
    end
    if (go_on) begin
      push_byte(8'hFF, 1'b0, 1'b1, msb, 1'b0);
      push_byte(8'hFF, 1'b1, 1'b1, lsb, 1'b0);
    end
    push(1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 1'b1);
    push(1'b1, 1'b1, 1'b1);
  endtask

  task automatic run_txn(input string name, input logic [7:0] addr, input logic [7:0] ptr,
                         input logic [7:0] msb, input logic [7:0] lsb, input int nack_idx,
                         input int go_hold, input int exp_len, input int pulse_at,
                         input int rst_at, input logic [15:0] exp_data, input logic exp_ack);
    int   wave_err, low_cnt, idle_err;
    logic prev_scl;
    logic obs[$];
    logic [7:0] b_w, b_p, b_r;
    wave_err = 0; low_cnt = 0; idle_err = 0; prev_scl = 1'b1;
    build(addr, ptr, msb, lsb, nack_idx);
    SLAVE_ADDRESS = addr;
    POINTER       = ptr;
    @(negedge PT_CK);
    GO = 1'b1;
    for (int i = 0; i < go_hold; i++) begin
      @(negedge PT_CK);
      if ({SDAO, SCLO} !== 2'b11 || END_OK !== 1'b1) idle_err++;
    end
    GO = 1'b0;
    check_eq({name, "/go_idle"}, idle_err, 0);
    @(negedge PT_CK);
    check_eq({name, "/launch_endok"}, END_OK, 1);
    for (int k = 0; k < exp_bus.size(); k++) begin
      @(negedge PT_CK);
      if ({SDAO, SCLO} !== exp_bus[k]) wave_err++;
      if (END_OK === 1'b0) low_cnt++;
      if (SCLO === 1'b1 && prev_scl === 1'b0) obs.push_back(SDAO);
      prev_scl = SCLO;
      SDAI = exp_sdai[k];
      if (pulse_at >= 0 && k == pulse_at)     GO = 1'b1;
      if (pulse_at >= 0 && k == pulse_at + 3) GO = 1'b0;
      if (k == rst_at) begin
        check_eq({name, "/wave_pre_rst"}, wave_err, 0);
        #1 RESET_N = 1'b0;
        #1;
        check_eq({name, "/rst_sdao"}, SDAO, 1);
        check_eq({name, "/rst_sclo"}, SCLO, 1);
        check_eq({name, "/rst_endok"}, END_OK, 1);
        check_eq({name, "/rst_ackok"}, ACK_OK, 0);
        check_eq({name, "/rst_data"}, DATA16, 16'h0000);
        SDAI = 1'b1;
        @(negedge PT_CK);
        @(negedge PT_CK);
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge PT_CK);
          if ({SDAO, SCLO} !== 2'b11 || END_OK !== 1'b1) idle_err++;
        end
        check_eq({name, "/post_rst_idle"}, idle_err, 0);
        return;
      end
    end
    SDAI = 1'b1;
    @(negedge PT_CK);
    check_eq({name, "/wave"}, wave_err, 0);
    check_eq({name, "/low_len"}, low_cnt, exp_len);
    check_eq({name, "/done_endok"}, END_OK, 1);
    check_eq({name, "/done_bus"}, {SDAO, SCLO}, 2'b11);
    check_eq({name, "/data16"}, DATA16, exp_data);
    check_eq({name, "/ack_ok"}, ACK_OK, exp_ack);
    if (nack_idx == 0) begin
      if (obs.size() >= 27) begin
        for (int i = 0; i < 8; i++) begin
          b_w[7-i] = obs[i];
          b_p[7-i] = obs[9+i];
          b_r[7-i] = obs[19+i];
        end
      end else begin
        b_w = 8'hXX; b_p = 8'hXX; b_r = 8'hXX;
      end
      check_eq({name, "/bus_waddr"}, b_w, {addr[7:1], 1'b0});
      check_eq({name, "/bus_ptr"}, b_p, ptr);
      check_eq({name, "/bus_raddr"}, b_r, {addr[7:1], 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge PT_CK);
      if ({SDAO, SCLO} !== 2'b11 || END_OK !== 1'b1) idle_err++;
    end
    check_eq({name, "/post_idle"}, idle_err, 0);
  endtask

  initial begin
    RESET_N       = 1'b0;
    GO            = 1'b0;
    SDAI          = 1'b1;
    SLAVE_ADDRESS = 8'h00;
    POINTER       = 8'h00;
    repeat (3) @(negedge PT_CK);
    check_eq("reset/sdao", SDAO, 1);
    check_eq("reset/sclo", SCLO, 1);
    check_eq("reset/endok", END_OK, 1);
    check_eq("reset/ackok", ACK_OK, 0);
    check_eq("reset/data", DATA16, 16'h0000);
    RESET_N = 1'b1;
    @(negedge PT_CK);

    run_txn("t1_basic", 8'h88, 8'h02, 8'hA5, 8'h3C, 0, 1, 142, -1, -1, 16'hA53C, 1'b1);
    run_txn("t2_go_busy", 8'h88, 8'h02, 8'h5A, 8'hC3, 0, 1, 142, 30, -1, 16'h5AC3, 1'b1);
    if (ABORT_EN)
      run_txn("t3_nack_abort", 8'h88, 8'h02, 8'h12, 8'h34, 2, 1, 58, -1, -1, 16'h5AC3, 1'b0);
    else
      run_txn("t3_nack_full", 8'h88, 8'h02, 8'h12, 8'h34, 2, 1, 142, -1, -1, 16'h1234, 1'b0);
    run_txn("t4_go_hold", 8'h88, 8'h02, 8'h80, 8'h01, 0, 20, 142, -1, -1, 16'h8001, 1'b1);
    run_txn("t5_reset", 8'h88, 8'h02, 8'h77, 8'h77, 0, 1, 142, -1, 90, 16'h0000, 1'b0);
    run_txn("t6_after_rst", 8'h88, 8'h02, 8'h00, 8'hFF, 0, 1, 142, -1, -1, 16'h00FF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
